// File: rtl/vend_pkg.sv
// Shared vending types: dispenser FSM states, coin denominations and coin values in quarters.
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StReq,
    StGap,
    StDone,
    StFault
  } disp_state_e;

  typedef enum logic [1:0] {
    Den1,
    Den05,
    Den025
  } den_e;

  localparam int unsigned CoinValue1   = 4;
  localparam int unsigned CoinValue05  = 2;
  localparam int unsigned CoinValue025 = 1;

  function automatic int unsigned coin_value(den_e den);
    int unsigned val;
    val = 0;
    unique case (den)
      Den1:    val = CoinValue1;
      Den05:   val = CoinValue05;
      Den025:  val = CoinValue025;
      default: val = 0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter that saturates at zero; tc_o flags the zero count.
module dispense_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Drives the coin hopper one coin at a time ($1 first, then 50c, then 25c) with a
// request/ack handshake, an enforced inter-coin gap and a sticky ack-timeout fault.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 200
) (
  input  logic             in_clka,
  input  logic             in_restart_n,
  input  logic             in_load,
  input  logic [CNT_W-1:0] in_change_1,
  input  logic             in_change_05,
  input  logic             in_change_025,
  input  logic             in_clear_fault,
  input  logic             in_hopper_ack,
  output logic             out_req_1,
  output logic             out_req_05,
  output logic             out_req_025,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_fault,
  output logic [CNT_W+1:0] out_coins_left
);

  localparam int unsigned TimerW = 8;
  localparam int unsigned LeftW  = CNT_W + 2;

  disp_state_e      state_d, state_q;
  den_e             den_d, den_q;
  logic [CNT_W-1:0] cnt1_d, cnt1_q;
  logic             f05_d, f05_q, f025_d, f025_q;
  logic             req1_d, req1_q, req05_d, req05_q, req025_d, req025_q;
  logic             busy_d, busy_q, done_d, done_q, fault_d, fault_q;
  logic [LeftW-1:0] left_d, left_q;
  logic             gap_load, ack_load, gap_tc, ack_tc;

  // Both timers are loaded with N-1 so the state they guard lasts exactly N cycles.
  dispense_timer #(.Width(TimerW)) u_gap_timer (
    .clk_i      (in_clka),
    .rst_ni     (in_restart_n),
    .load_i     (gap_load),
    .load_val_i (TimerW'(GAP_CYCLES - 1)),
    .en_i       (state_q == StGap),
    .tc_o       (gap_tc)
  );

  dispense_timer #(.Width(TimerW)) u_ack_timer (
    .clk_i      (in_clka),
    .rst_ni     (in_restart_n),
    .load_i     (ack_load),
    .load_val_i (TimerW'(ACK_TIMEOUT - 1)),
    .en_i       (state_q == StReq),
    .tc_o       (ack_tc)
  );

  always_comb begin
    state_d  = state_q;
    den_d    = den_q;
    cnt1_d   = cnt1_q;
    f05_d    = f05_q;
    f025_d   = f025_q;
    req1_d   = 1'b0;
    req05_d  = 1'b0;
    req025_d = 1'b0;
    done_d   = 1'b0;
    fault_d  = fault_q;
    gap_load = 1'b0;
    ack_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_load) begin
          cnt1_d  = in_change_1;
          f05_d   = in_change_05;
          f025_d  = in_change_025;
          state_d = StSel;
        end
      end
      StSel: begin
        ack_load = 1'b1;
        state_d  = StReq;
        if (cnt1_q != '0) begin
          den_d  = Den1;
          req1_d = 1'b1;
        end else if (f05_q) begin
          den_d   = Den05;
          req05_d = 1'b1;
        end else if (f025_q) begin
          den_d    = Den025;
          req025_d = 1'b1;
        end else begin
          ack_load = 1'b0;
          state_d  = StDone;
          done_d   = 1'b1;
        end
      end
      StReq: begin
        if (in_hopper_ack) begin
          unique case (den_q)
            Den1:    if (cnt1_q != '0) cnt1_d = cnt1_q - CNT_W'(1);
            Den05:   f05_d = 1'b0;
            Den025:  f025_d = 1'b0;
            default: ;
          endcase
          gap_load = 1'b1;
          state_d  = StGap;
        end else if (ack_tc) begin
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          req1_d   = req1_q;
          req05_d  = req05_q;
          req025_d = req025_q;
        end
      end
      StGap: begin
        if (gap_tc) state_d = StSel;
      end
      StDone: begin
        state_d = StIdle;
      end
      StFault: begin
        if (in_clear_fault) begin
          cnt1_d  = '0;
          f05_d   = 1'b0;
          f025_d  = 1'b0;
          fault_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    left_d = LeftW'(cnt1_d) + LeftW'(f05_d) + LeftW'(f025_d);
  end

  always_ff @(posedge in_clka or negedge in_restart_n) begin
    if (!in_restart_n) begin
      state_q  <= StIdle;
      den_q    <= Den1;
      cnt1_q   <= '0;
      f05_q    <= 1'b0;
      f025_q   <= 1'b0;
      req1_q   <= 1'b0;
      req05_q  <= 1'b0;
      req025_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      left_q   <= '0;
    end else begin
      state_q  <= state_d;
      den_q    <= den_d;
      cnt1_q   <= cnt1_d;
      f05_q    <= f05_d;
      f025_q   <= f025_d;
      req1_q   <= req1_d;
      req05_q  <= req05_d;
      req025_q <= req025_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      left_q   <= left_d;
    end
  end

  assign out_req_1      = req1_q;
  assign out_req_05     = req05_q;
  assign out_req_025    = req025_q;
  assign out_busy       = busy_q;
  assign out_done       = done_q;
  assign out_fault      = fault_q;
  assign out_coins_left = left_q;

endmodule
